missile_scheduler: RTL and testbench
====================================

# missile_scheduler

Allocates the player's eight missile slots in the VGA peripheral. It turns a raw fire button into single-slot launch commands and enforces a refire cooldown. It tracks which slots are in flight and frees each slot when that missile hits a target or leaves the screen. Its slot enable vector drives the missile datapath's per-slot enable inputs, and its motion tick paces both that datapath and the cooldown.

## Interface
Parameters:
- NUM_SLOTS, 8, number of missile slots; fixed at 8 for the current datapath. Slot index width is 3.
- TICK_DIV, 250000, clk cycles per motion tick.
- COOLDOWN_TICKS, 8, motion ticks that must elapse after a launch before the next fire is accepted; legal range 1..255.

Ports:
- clk  in  1  system clock (31.5 MHz pixel clock domain).
- rst  in  1  reset; asynchronous, active-low.
- fire_req  in  1  raw fire button level, asynchronous to clk.
- hit_valid  in  1  one-cycle pulse: the missile in hit_slot struck an alien.
- hit_slot  in  3  slot index qualified by hit_valid.
- offscreen  in  8  per-slot one-cycle pulse: that missile reached row 0.
- slot_en  out  8  per-slot in-flight level; bit i=1 means slot i is launched.
- fire_ack  out  1  one-cycle pulse: a launch was granted.
- fire_slot  out  3  slot granted; valid only while fire_ack=1, otherwise held.
- fire_drop  out  1  one-cycle pulse: a fire edge was rejected (cooldown or no free slot).
- motion_tick  out  1  one-cycle pulse every TICK_DIV cycles.
- cooldown_active  out  1  high while in the COOLDOWN state.
- shots_fired  out  16  count of granted launches; wraps from 0xFFFF to 0.

## Operation
- Input conditioning: fire_req passes through a 2-flop synchronizer followed by a registered rising-edge detector, which yields fire_edge.
- Tick generator: 18-bit counter runs 0..TICK_DIV-1. motion_tick=1 in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- FSM states: IDLE and COOLDOWN.
  - IDLE, fire_edge, any slot free: grant the lowest-index free slot. slot_en[k] is set and fire_ack pulses with fire_slot=k. shots_fired increments. The cooldown counter loads COOLDOWN_TICKS and the FSM moves to COOLDOWN.
  - IDLE, fire_edge, all 8 slots busy: fire_drop pulses and the FSM stays in IDLE.
  - COOLDOWN: the counter decrements on each motion_tick. When it reaches 0, the FSM returns to IDLE on the next cycle. Any fire_edge in this state pulses fire_drop.
- Retire: hit_valid clears slot_en[hit_slot]; offscreen[i] clears slot_en[i]. Several retires in one cycle all take effect. A retire aimed at an already-free slot is ignored.
- Free-slot selection uses the slot_en value registered in the current cycle. A slot retired in cycle N can be granted no earlier than cycle N+1.
- Grant and retire of different slots in the same cycle both take effect.
- Reset mid-flight: all slots are abandoned and slot_en goes to 0.

## Timing
- Reset values: slot_en=0, fire_ack=0, fire_slot=0, fire_drop=0, motion_tick=0, cooldown_active=0, shots_fired=0. After reset the FSM is in IDLE, the tick counter is 0 and the synchronizer and edge detector are cleared.
- Fire latency: fire_req is first sampled high at edge E. fire_ack (or fire_drop) is asserted from edge E+3 and lasts one cycle. The slot_en bit rises at that same edge.
- Holding fire_req high produces exactly one fire_edge. A new edge requires fire_req to be low for at least 2 cycles.
- Retire latency: a retire pulse at edge E clears the slot_en bit at edge E+1.
- Cooldown duration: from the fire_ack cycle through the COOLDOWN_TICKS-th motion_tick, plus one cycle. cooldown_active is high for exactly that span.
- Only one grant can occur per cooldown window, so at most one launch happens per cycle.
- All outputs are registered.

## Test plan
- Reset with fire_req held high, then release rst. Required: all outputs stay 0 until fire_req is low, then high again. The new press gives fire_ack at E+3 with fire_slot=0, slot_en=0x01 and shots_fired=1.
- Press fire 9 times, each press after the cooldown expires, with no retires. Required: slots 0..7 are granted in order and slot_en=0xFF. The 9th press gives fire_drop=1 and slot_en is unchanged.
- Start with slot_en=0xFF. Pulse hit_valid with hit_slot=5 and offscreen[2] in the same cycle. Required: slot_en=0xDB one cycle later. The next fire is granted slot 2.
- Use TICK_DIV=4 and COOLDOWN_TICKS=3. Fire once, then press again at 5 cycles and at 20 cycles after the ack. Required: the first re-press gives fire_drop; the second is granted.
- Start with slots 0..6 busy. In one cycle, offscreen[7] arrives while a fire grant to slot 7 is in progress. Required: slot 7 is granted; a retire pulse for slot 7 arriving a cycle later clears it.
- Assert rst low while 3 missiles are in flight and the FSM is in COOLDOWN. Required: all outputs go to 0 asynchronously with no clk edge needed. After release, the first press is granted slot 0.

Source files
------------

// File: rtl/missile_scheduler.sv
//------------------------------------------------------------------------------
// missile_scheduler : allocates eight missile slots, paces motion ticks and
//                     enforces a refire cooldown between launches.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module missile_scheduler #(
  parameter int NUM_SLOTS      = 8,
  parameter int TICK_DIV       = 250000,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fire_req,
  input  logic                 hit_valid,
  input  logic [2:0]           hit_slot,
  input  logic [NUM_SLOTS-1:0] offscreen,
  output logic [NUM_SLOTS-1:0] slot_en,
  output logic                 fire_ack,
  output logic [2:0]           fire_slot,
  output logic                 fire_drop,
  output logic                 motion_tick,
  output logic                 cooldown_active,
  output logic [15:0]          shots_fired
);

  localparam logic [17:0] TICK_LAST = 18'(TICK_DIV - 1);
  localparam logic [7:0]  CD_LOAD   = 8'(COOLDOWN_TICKS);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cd_q, cd_d;
  logic [17:0]          tick_cnt_q, tick_cnt_d;
  logic                 motion_tick_q, motion_tick_d;
  logic                 sync1_q, sync2_q, sync3_q;
  logic [1:0]           fill_q, fill_d;
  logic                 armed_q, armed_d;
  logic                 fire_edge_q, fire_edge_d;
  logic [NUM_SLOTS-1:0] slot_en_q, slot_en_d;
  logic                 fire_ack_q, fire_ack_d;
  logic [2:0]           fire_slot_q, fire_slot_d;
  logic                 fire_drop_q, fire_drop_d;
  logic                 cooldown_active_q, cooldown_active_d;
  logic [15:0]          shots_q, shots_d;

  logic                 free_found;
  logic [2:0]           free_idx;
  logic                 grant;
  logic                 drop;
  logic [NUM_SLOTS-1:0] retire_mask;
  logic [NUM_SLOTS-1:0] grant_mask;

  // The synchronizer only reflects a real pin sample two cycles after reset;
  // arming waits for a genuine low so a button held through reset is ignored.
  always_comb begin
    fill_d      = {fill_q[0], 1'b1};
    armed_d     = armed_q | (fill_q[1] & ~sync2_q);
    fire_edge_d = sync2_q & ~sync3_q & armed_q;
  end

  always_comb begin
    tick_cnt_d    = (tick_cnt_q == TICK_LAST) ? 18'd0 : tick_cnt_q + 18'd1;
    motion_tick_d = (tick_cnt_d == TICK_LAST);
  end

  // Lowest-index free slot: scan downward so the last hit wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_en_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    grant   = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire_edge_q) begin
          if (free_found) begin
            grant   = 1'b1;
            cd_d    = CD_LOAD;
            state_d = ST_COOLDOWN;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_COOLDOWN: begin
        if (fire_edge_q) drop = 1'b1;
        if (cd_q == 8'd0) begin
          state_d = ST_IDLE;
        end else if (motion_tick_q) begin
          cd_d = cd_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant is OR-ed in after the retire mask, so a retire aimed at the slot
  // being granted (necessarily free) cannot cancel the launch.
  always_comb begin
    retire_mask = offscreen;
    if (hit_valid) retire_mask[hit_slot] = 1'b1;
    grant_mask = '0;
    if (grant) grant_mask[free_idx] = 1'b1;
    slot_en_d         = (slot_en_q & ~retire_mask) | grant_mask;
    fire_ack_d        = grant;
    fire_drop_d       = drop;
    fire_slot_d       = grant ? free_idx : fire_slot_q;
    shots_d           = shots_q + {15'd0, grant};
    cooldown_active_d = (state_d == ST_COOLDOWN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= ST_IDLE;
      cd_q              <= 8'd0;
      tick_cnt_q        <= 18'd0;
      motion_tick_q     <= 1'b0;
      sync1_q           <= 1'b0;
      sync2_q           <= 1'b0;
      sync3_q           <= 1'b0;
      fill_q            <= 2'b00;
      armed_q           <= 1'b0;
      fire_edge_q       <= 1'b0;
      slot_en_q         <= '0;
      fire_ack_q        <= 1'b0;
      fire_slot_q       <= 3'd0;
      fire_drop_q       <= 1'b0;
      cooldown_active_q <= 1'b0;
      shots_q           <= 16'd0;
    end else begin
      state_q           <= state_d;
      cd_q              <= cd_d;
      tick_cnt_q        <= tick_cnt_d;
      motion_tick_q     <= motion_tick_d;
      sync1_q           <= fire_req;
      sync2_q           <= sync1_q;
      sync3_q           <= sync2_q;
      fill_q            <= fill_d;
      armed_q           <= armed_d;
      fire_edge_q       <= fire_edge_d;
      slot_en_q         <= slot_en_d;
      fire_ack_q        <= fire_ack_d;
      fire_slot_q       <= fire_slot_d;
      fire_drop_q       <= fire_drop_d;
      cooldown_active_q <= cooldown_active_d;
      shots_q           <= shots_d;
    end
  end

  assign slot_en         = slot_en_q;
  assign fire_ack        = fire_ack_q;
  assign fire_slot       = fire_slot_q;
  assign fire_drop       = fire_drop_q;
  assign motion_tick     = motion_tick_q;
  assign cooldown_active = cooldown_active_q;
  assign shots_fired     = shots_q;

endmodule

`default_nettype wire

// File: tb/tb_missile_scheduler.sv
//------------------------------------------------------------------------------
// tb_missile_scheduler : directed bench for missile_scheduler (TICK_DIV=4,
//                        COOLDOWN_TICKS=3).
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_missile_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        fire_req;
  logic        hit_valid;
  logic [2:0]  hit_slot;
  logic [7:0]  offscreen;
  logic [7:0]  slot_en;
  logic        fire_ack;
  logic [2:0]  fire_slot;
  logic        fire_drop;
  logic        motion_tick;
  logic        cooldown_active;
  logic [15:0] shots_fired;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  missile_scheduler #(
    .NUM_SLOTS      (8),
    .TICK_DIV       (4),
    .COOLDOWN_TICKS (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fire_req        (fire_req),
    .hit_valid       (hit_valid),
    .hit_slot        (hit_slot),
    .offscreen       (offscreen),
    .slot_en         (slot_en),
    .fire_ack        (fire_ack),
    .fire_slot       (fire_slot),
    .fire_drop       (fire_drop),
    .motion_tick     (motion_tick),
    .cooldown_active (cooldown_active),
    .shots_fired     (shots_fired)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".slot_en"},  32'(slot_en),         32'h0);
    chk({tag, ".ack"},      32'(fire_ack),        32'h0);
    chk({tag, ".slot"},     32'(fire_slot),       32'h0);
    chk({tag, ".drop"},     32'(fire_drop),       32'h0);
    chk({tag, ".tick"},     32'(motion_tick),     32'h0);
    chk({tag, ".cooldown"}, 32'(cooldown_active), 32'h0);
    chk({tag, ".shots"},    32'(shots_fired),     32'h0);
  endtask

  // One button press; the decision is visible three edges after first sample.
  task automatic press(input logic exp_grant, input logic [2:0] exp_slot,
                       input logic [7:0] exp_en, input logic [15:0] exp_shots,
                       input string tag);
    fire_req = 1'b1;
    step(3);
    chk({tag, ".early_ack"}, 32'(fire_ack | fire_drop), 32'h0);
    step(1);
    chk({tag, ".ack"},  32'(fire_ack),  32'(exp_grant));
    chk({tag, ".drop"}, 32'(fire_drop), 32'(!exp_grant));
    if (exp_grant) chk({tag, ".slot"}, 32'(fire_slot), 32'(exp_slot));
    chk({tag, ".slot_en"}, 32'(slot_en),     32'(exp_en));
    chk({tag, ".shots"},   32'(shots_fired), 32'(exp_shots));
    step(1);
    fire_req = 1'b0;
    chk({tag, ".pulse_end"}, 32'(fire_ack | fire_drop), 32'h0);
    step(15);
  endtask

  initial begin
    rst       = 1'b0;
    fire_req  = 1'b1;
    hit_valid = 1'b0;
    hit_slot  = 3'd0;
    offscreen = 8'h00;

    // Reset held with the button pressed
    step(3);
    chk_all_zero("reset");
    #2 rst = 1'b1;
    step(3);
    chk("tick_first", 32'(motion_tick), 32'h1);
    step(1);
    chk("tick_clear", 32'(motion_tick), 32'h0);
    step(6);
    chk("held.ack",     32'(fire_ack),    32'h0);
    chk("held.drop",    32'(fire_drop),   32'h0);
    chk("held.slot_en", 32'(slot_en),     32'h0);
    chk("held.shots",   32'(shots_fired), 32'h0);
    fire_req = 1'b0;
    step(4);

    // Fill all eight slots, then one press too many
    press(1'b1, 3'd0, 8'h01, 16'd1, "fill0");
    for (int i = 1; i < 8; i++)
      press(1'b1, 3'(i), 8'((1 << (i + 1)) - 1), 16'(i + 1), "fill");
    press(1'b0, 3'd0, 8'hFF, 16'd8, "full_drop");

    // Simultaneous hit on slot 5 and offscreen on slot 2
    hit_valid = 1'b1;
    hit_slot  = 3'd5;
    offscreen = 8'h04;
    step(1);
    hit_valid = 1'b0;
    offscreen = 8'h00;
    chk("dual_retire", 32'(slot_en), 32'hDB);
    press(1'b1, 3'd2, 8'hDF, 16'd9,  "refill2");
    press(1'b1, 3'd5, 8'hFF, 16'd10, "refill5");

    // Cooldown: re-press at ack+5 is dropped, at ack+20 granted
    offscreen = 8'h09;
    step(1);
    offscreen = 8'h00;
    chk("free0_3", 32'(slot_en), 32'hF6);
    fire_req = 1'b1;
    step(4);
    chk("cd.ack",      32'(fire_ack),        32'h1);
    chk("cd.slot",     32'(fire_slot),       32'h0);
    chk("cd.slot_en",  32'(slot_en),         32'hF7);
    chk("cd.active",   32'(cooldown_active), 32'h1);
    step(1);
    fire_req = 1'b0;
    step(4);
    fire_req = 1'b1;
    step(4);
    chk("cd.early_drop", 32'(fire_drop),   32'h1);
    chk("cd.early_ack",  32'(fire_ack),    32'h0);
    chk("cd.early_en",   32'(slot_en),     32'hF7);
    chk("cd.early_shot", 32'(shots_fired), 32'd11);
    step(1);
    fire_req = 1'b0;
    step(10);
    chk("cd.expired", 32'(cooldown_active), 32'h0);
    fire_req = 1'b1;
    step(4);
    chk("cd.late_ack",  32'(fire_ack),    32'h1);
    chk("cd.late_slot", 32'(fire_slot),   32'h3);
    chk("cd.late_en",   32'(slot_en),     32'hFF);
    chk("cd.late_shot", 32'(shots_fired), 32'd12);
    step(1);
    fire_req = 1'b0;
    step(15);

    // Offscreen for slot 7 in the same cycle slot 7 is granted
    hit_valid = 1'b1;
    hit_slot  = 3'd7;
    step(1);
    hit_valid = 1'b0;
    chk("free7", 32'(slot_en), 32'h7F);
    fire_req = 1'b1;
    step(3);
    offscreen = 8'h80;
    step(1);
    offscreen = 8'h00;
    chk("race.ack",   32'(fire_ack),    32'h1);
    chk("race.slot",  32'(fire_slot),   32'h7);
    chk("race.en",    32'(slot_en),     32'hFF);
    chk("race.shots", 32'(shots_fired), 32'd13);
    hit_valid = 1'b1;
    hit_slot  = 3'd7;
    fire_req  = 1'b0;
    step(1);
    hit_valid = 1'b0;
    chk("race.retire", 32'(slot_en), 32'h7F);
    step(16);

    // Asynchronous reset with three in flight during cooldown
    offscreen = 8'h7C;
    step(1);
    offscreen = 8'h00;
    chk("keep2", 32'(slot_en), 32'h03);
    fire_req = 1'b1;
    step(4);
    chk("mid.ack",    32'(fire_ack),        32'h1);
    chk("mid.slot",   32'(fire_slot),       32'h2);
    chk("mid.en",     32'(slot_en),         32'h07);
    chk("mid.active", 32'(cooldown_active), 32'h1);
    fire_req = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2 rst = 1'b1;
    step(5);
    press(1'b1, 3'd0, 8'h01, 16'd1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
